// File: rtl/booth_pkg.sv
// Shared Booth radix-4 definitions: digit-select encoding, window decoder, FSM states.
package booth_pkg;

  typedef struct packed {
    logic zero;
    logic one;
    logic two;
    logic neg1;
    logic neg2;
  } booth_sel_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } booth_state_t;

  // Window {y[2i+1], y[2i], y[2i-1]} to one-hot digit select.
  function automatic booth_sel_t booth_decode(input logic [2:0] win);
    booth_sel_t sel;
    sel = '0;
    case (win)
      3'b000, 3'b111: sel.zero = 1'b1;
      3'b001, 3'b010: sel.one  = 1'b1;
      3'b011:         sel.two  = 1'b1;
      3'b100:         sel.neg2 = 1'b1;
      default:        sel.neg1 = 1'b1;  // 101, 110
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/booth_radix4_seq_mul_if.sv
// Operand/product valid-ready bus of the sequential Booth multiplier.
interface booth_radix4_seq_mul_if #(
  parameter int WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport master (
    output in_valid, multiplicand, multiplier, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, multiplicand, multiplier, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/booth_pp_select.sv
// Combinational Booth partial-product selector: 0, +-X or +-2X (unshifted).
module booth_pp_select
  import booth_pkg::*;
#(
  parameter int PW = 32
) (
  input  logic [2:0]    window,
  input  logic [PW-1:0] x,
  output logic [PW-1:0] pp
);

  booth_sel_t sel;

  // Decode the window and pick the matching multiple of X.
  always_comb begin
    sel = booth_decode(window);
    pp  = '0;
    if (sel.zero)      pp = '0;
    else if (sel.one)  pp = x;
    else if (sel.two)  pp = x << 1;
    else if (sel.neg1) pp = -x;
    else if (sel.neg2) pp = -(x << 1);
  end

endmodule

// File: rtl/booth_radix4_seq_mul.sv
// Sequential signed radix-4 Booth multiplier, one digit per cycle, valid/ready on both sides.
module booth_radix4_seq_mul
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  booth_radix4_seq_mul_if.slave   bus
);

  localparam int DIGITS = WIDTH / 2;
  localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW     = 2 * WIDTH;

  booth_state_t     state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    x_sh;
  logic [WIDTH-1:0] y_sr;
  logic             prev;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    pp;
  logic             in_ready_w, out_valid_w, busy_w;
  logic             last_digit;

  assign last_digit = (cnt == CW'(DIGITS - 1));

  // X is pre-shifted each digit, so the selector output already carries the 2i weight.
  booth_pp_select #(.PW(PW)) u_pp_select (
    .window (({y_sr[1], y_sr[0], prev})),
    .x      (x_sh),
    .pp     (pp)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid && in_ready_w) state_nxt = RUN;
      RUN:     if (last_digit)                 state_nxt = DONE;
      DONE:    if (out_valid_w && bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from the registered state only.
  always_comb begin
    in_ready_w  = (state == IDLE);
    busy_w      = (state == RUN);
    out_valid_w = (state == DONE);
  end

  // Operand latch, multiplier/multiplicand shift registers, digit counter and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      x_sh <= '0;
      y_sr <= '0;
      prev <= 1'b0;
      acc  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_w) begin
            x_sh <= {{WIDTH{bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
            y_sr <= bus.multiplier;
            prev <= 1'b0;
            acc  <= '0;
            cnt  <= '0;
          end
        end
        RUN: begin
          acc  <= acc + pp;
          x_sh <= x_sh << 2;
          y_sr <= y_sr >> 2;
          prev <= y_sr[1];
          cnt  <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.busy      = busy_w;
  assign bus.product   = acc;

endmodule

// File: tb/tb_booth_radix4_seq_mul.sv
// Self-checking bench for booth_radix4_seq_mul (WIDTH=16).
module tb_booth_radix4_seq_mul;

  localparam int W = 16;
  localparam int LAT = W / 2;

  logic clk;
  logic rst_n;

  booth_radix4_seq_mul_if #(.WIDTH(W)) bus ();

  booth_radix4_seq_mul #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_issued = 0;
  int n_out = 0;
  bit rand_or = 0;

  // Model state: a transaction is either running (cycles left), done, or absent.
  int                m_run_left = 0;
  bit                m_done = 0;
  logic [2*W-1:0]    m_q[$];
  logic [2*W-1:0]    m_hold = '0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] sa, sb;
    sa = {{W{a[W-1]}}, a};
    sb = {{W{b[W-1]}}, b};
    return sa * sb;
  endfunction

  // Compare process: check every cycle against the model, then advance the model for the next edge.
  always @(negedge clk) begin
    bit idle;
    if (!rst_n) begin
      m_run_left = 0;
      m_done     = 0;
      m_q.delete();
      m_hold     = '0;
    end
    idle = (m_run_left == 0) && !m_done;
    check("in_ready",  bus.in_ready,  idle);
    check("busy",      bus.busy,      m_run_left > 0);
    check("out_valid", bus.out_valid, m_done);
    if (m_done) begin
      if (m_q.size() != 0) check("product", bus.product, m_q[0]);
    end else if (idle) begin
      check("product_hold", bus.product, m_hold);
    end
    if (rst_n) begin
      if (m_done) begin
        if (bus.out_ready) begin
          m_hold = m_q.pop_front();
          m_done = 0;
          n_out++;
        end
      end else if (m_run_left > 0) begin
        m_run_left--;
        if (m_run_left == 0) m_done = 1;
      end else if (bus.in_valid) begin
        m_q.push_back(ref_mul(bus.multiplicand, bus.multiplier));
        m_run_left = LAT;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_or) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 200; k++) begin
      if (bus.in_ready) return;
      tick();
    end
    check("in_ready_timeout", bus.in_ready, 1);
  endtask

  // Directed operation with literal expectations for latency and product.
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] lit);
    int lat;
    bit seen;
    wait_ready();
    bus.in_valid = 1; bus.multiplicand = a; bus.multiplier = b;
    tick();
    n_issued++;
    bus.in_valid = 0;
    bus.multiplicand = W'($urandom);
    bus.multiplier   = W'($urandom);
    lat = 0; seen = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      lat++;
      if (bus.out_valid) begin seen = 1; break; end
    end
    if (!seen) begin
      check("out_valid_timeout", 0, 1);
    end else begin
      check("latency", lat, LAT);
      check("literal_product", bus.product, lit);
      if (bus.out_ready) begin
        tick();
        check("out_valid_one_cycle", bus.out_valid, 0);
        check("product_after_done", bus.product, lit);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    bus.in_valid = 0;
    bus.out_ready = 1;
    bus.multiplicand = '0;
    bus.multiplier = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_product", bus.product, 0);
    check("reset_in_ready", bus.in_ready, 1);
    rst_n = 1;
    tick();

    op(16'd3, 16'd5, 32'h0000000F);
    op(16'hFFF9, 16'd6, 32'hFFFFFFD6);
    op(16'd1234, 16'hFFFF, 32'hFFFFFB2E);
    op(16'h8000, 16'h8000, 32'h40000000);
    op(16'h7FFF, 16'h7FFF, 32'h3FFF0001);
    op(16'h8000, 16'h7FFF, 32'hC0008000);

    // Backpressure: hold the product in DONE, ignore new operands.
    bus.out_ready = 0;
    op(16'd100, 16'hFF9C, 32'hFFFFD8F0);
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.multiplicand = W'($urandom);
      bus.multiplier   = W'($urandom);
      tick();
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_product", bus.product, 32'hFFFFD8F0);
    end
    bus.in_valid = 0;
    bus.out_ready = 1;
    tick();
    check("bp_release_idle", bus.in_ready, 1);
    check("bp_release_ov", bus.out_valid, 0);
    op(16'd7, 16'd9, 32'h0000003F);

    // Reset in the middle of a run aborts it.
    wait_ready();
    bus.in_valid = 1; bus.multiplicand = 16'd5; bus.multiplier = 16'd7;
    tick();
    bus.in_valid = 0;
    repeat (3) tick();
    rst_n = 0;
    #1;
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_product", bus.product, 0);
    check("abort_in_ready", bus.in_ready, 1);
    bus.in_valid = 1;
    tick();
    bus.in_valid = 0;
    rst_n = 1;
    tick();
    op(16'd2, 16'hFFFD, 32'hFFFFFFFA);

    // Random signed pairs with input gaps and random consumer backpressure.
    rand_or = 1;
    for (int n = 0; n < 3000; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) tick();
      wait_ready();
      bus.in_valid = 1;
      bus.multiplicand = W'($urandom);
      bus.multiplier   = W'($urandom);
      if (n % 50 == 0) bus.multiplicand = 16'h8000;
      tick();
      n_issued++;
      bus.in_valid = 0;
    end
    rand_or = 0;
    bus.out_ready = 1;
    tick();
    wait_ready();
    tick();
    check("transaction_count", n_out, n_issued);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
